// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the ibus/dbus to memory-port arbiter: bus request/response
// structs, access sizes, arbiter state and grant encodings.
package mem_bus_arbiter_pkg;

  localparam int ADDR_W = 64;
  localparam int WORD_W = 64;
  localparam int STRB_W = 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [STRB_W-1:0] strobe_t;

  typedef enum logic [2:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;

  typedef struct packed {
    logic  valid;
    addr_t addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic    valid;
    addr_t   addr;
    msize_t  size;
    strobe_t strobe;
    word_t   data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D} arb_state_t;
  typedef enum logic {ARB_SEL_I, ARB_SEL_D} arb_sel_t;

  // A 32-bit fetch lives in one half of the 64-bit memory word.
  function automatic logic [31:0] half_select(word_t data, logic upper);
    return upper ? data[63:32] : data[31:0];
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the fetch, memory-stage and memory-side buses around the arbiter.
interface mem_bus_arbiter_if;
  import mem_bus_arbiter_pkg::*;

  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  dbus_req_t  oreq;
  dbus_resp_t oresp;

  modport slave (
    input  ireq, dreq, oresp,
    output iresp, dresp, oreq
  );

  modport master (
    output ireq, dreq, oresp,
    input  iresp, dresp, oreq
  );
endinterface

// File: rtl/mem_bus_arbiter_arb_pick.sv
// Two-way chooser: a lone requester wins; on a tie the one opposite last_grant wins.
module mem_bus_arbiter_arb_pick
  import mem_bus_arbiter_pkg::*;
(
  input  logic     ivalid_i,
  input  logic     dvalid_i,
  input  arb_sel_t last_grant_i,
  output arb_sel_t sel_o,
  output logic     any_o
);

  always_comb begin
    any_o = ivalid_i | dvalid_i;
    if (ivalid_i && dvalid_i) begin
      sel_o = (last_grant_i == ARB_SEL_D) ? ARB_SEL_I : ARB_SEL_D;
    end else if (dvalid_i) begin
      sel_o = ARB_SEL_D;
    end else begin
      sel_o = ARB_SEL_I;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the memory port between fetch (ibus) and memory stage (dbus), locking
// the grant until addr_ok & data_ok. Define MEM_BUS_ARBITER_RR_EN for round-robin ties.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  mem_bus_arbiter_if.slave   bus
);

  arb_state_t state_q, state_d;
  arb_sel_t   sel, pick_sel, last_grant;
  logic       pick_any, granted, done;

  assign done = bus.oresp.addr_ok & bus.oresp.data_ok;

`ifdef MEM_BUS_ARBITER_RR_EN
  arb_sel_t last_grant_q;
  assign last_grant = last_grant_q;
`else
  // A constant "last was I" makes every tie resolve to D.
  assign last_grant = ARB_SEL_I;
`endif

  mem_bus_arbiter_arb_pick u_pick (
    .ivalid_i     (bus.ireq.valid),
    .dvalid_i     (bus.dreq.valid),
    .last_grant_i (last_grant),
    .sel_o        (pick_sel),
    .any_o        (pick_any)
  );

  always_comb begin
    sel     = pick_sel;
    granted = 1'b0;
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        granted = pick_any;
        if (pick_any && !done) begin
          state_d = (pick_sel == ARB_SEL_D) ? ARB_BUSY_D : ARB_BUSY_I;
        end
      end
      ARB_BUSY_I: begin
        granted = 1'b1;
        sel     = ARB_SEL_I;
        if (done) state_d = ARB_IDLE;
      end
      ARB_BUSY_D: begin
        granted = 1'b1;
        sel     = ARB_SEL_D;
        if (done) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
`ifdef MEM_BUS_ARBITER_RR_EN
      last_grant_q <= ARB_SEL_D;
`endif
    end else begin
      state_q <= state_d;
`ifdef MEM_BUS_ARBITER_RR_EN
      if (granted && done) last_grant_q <= sel;
`endif
    end
  end

  // Zero-latency forwarding; the memory side sees nothing while reset is held.
  always_comb begin
    bus.oreq  = '0;
    bus.iresp = '0;
    bus.dresp = '0;
    if (!reset) begin
      bus.dresp.data = bus.oresp.data;
      bus.iresp.data = half_select(bus.oresp.data, bus.ireq.addr[2]);
      if (granted) begin
        if (sel == ARB_SEL_D) begin
          bus.oreq          = bus.dreq;
          bus.dresp.addr_ok = bus.oresp.addr_ok;
          bus.dresp.data_ok = bus.oresp.data_ok;
        end else begin
          bus.oreq.valid    = bus.ireq.valid;
          bus.oreq.addr     = bus.ireq.addr;
          bus.oreq.size     = MSIZE4;
          bus.iresp.addr_ok = bus.oresp.addr_ok;
          bus.iresp.data_ok = bus.oresp.data_ok;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios then protocol-legal random traffic,
// all checked against a transaction-level owner/last-winner model.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_bus_arbiter_if bus();
  mem_bus_arbiter dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int n_chk  = 0;
  int n_pass = 0;

  // Model: who holds the port (0 none, 1 fetch, 2 memory stage) and who last completed.
  int   owner = 0;
  int   last  = 2;
  logic done_i, done_d;
  dbus_req_t  s_oreq;
  ibus_resp_t s_iresp;
  dbus_resp_t s_dresp;

  localparam addr_t DADDR = 64'h0000_0000_8000_0010;
  localparam word_t DDATA = 64'h1122_3344_5566_7788;
  localparam word_t MDATA = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam addr_t IADDR = 64'h0000_0000_8000_0004;

  task automatic check(string tag, logic [191:0] got, logic [191:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic int who_serves();
    if (owner != 0) return owner;
    if (bus.dreq.valid && bus.ireq.valid) begin
`ifdef MEM_BUS_ARBITER_RR_EN
      return (last == 2) ? 1 : 2;
`else
      return 2;
`endif
    end
    if (bus.dreq.valid) return 2;
    if (bus.ireq.valid) return 1;
    return 0;
  endfunction

  task automatic step();
    dbus_req_t  eo;
    ibus_resp_t ei;
    dbus_resp_t ed;
    logic       done;
    int         cur;
    @(negedge clk);
    cur  = who_serves();
    done = bus.oresp.addr_ok & bus.oresp.data_ok;
    eo = '0; ei = '0; ed = '0;
    if (!reset) begin
      ed.data = bus.oresp.data;
      ei.data = bus.ireq.addr[2] ? bus.oresp.data[63:32] : bus.oresp.data[31:0];
      if (cur == 2) begin
        eo         = bus.dreq;
        ed.addr_ok = bus.oresp.addr_ok;
        ed.data_ok = bus.oresp.data_ok;
      end else if (cur == 1) begin
        eo.valid   = bus.ireq.valid;
        eo.addr    = bus.ireq.addr;
        eo.size    = MSIZE4;
        ei.addr_ok = bus.oresp.addr_ok;
        ei.data_ok = bus.oresp.data_ok;
      end
    end
    s_oreq = bus.oreq; s_iresp = bus.iresp; s_dresp = bus.dresp;
    check("oreq",  192'(bus.oreq),  192'(eo));
    check("iresp", 192'(bus.iresp), 192'(ei));
    check("dresp", 192'(bus.dresp), 192'(ed));
    @(posedge clk);
    done_i = 1'b0;
    done_d = 1'b0;
    if (reset) begin
      owner = 0;
      last  = 2;
    end else if (cur != 0) begin
      if (done) begin
        owner  = 0;
        last   = cur;
        done_i = (cur == 1);
        done_d = (cur == 2);
      end else begin
        owner = cur;
      end
    end
    #1;
  endtask

  task automatic drive_d(logic v, addr_t a, msize_t s, strobe_t st, word_t d);
    bus.dreq.valid = v; bus.dreq.addr = a; bus.dreq.size = s;
    bus.dreq.strobe = st; bus.dreq.data = d;
  endtask

  task automatic drive_i(logic v, addr_t a);
    bus.ireq.valid = v; bus.ireq.addr = a;
  endtask

  task automatic mem(logic ok, word_t d);
    bus.oresp.addr_ok = ok; bus.oresp.data_ok = ok; bus.oresp.data = d;
  endtask

  initial begin
    reset = 1'b1;
    bus.ireq = '0; bus.dreq = '0; bus.oresp = '0;
    step(); step();
    reset = 1'b0;
    step();
    check("rst_oreq", 192'(s_oreq), 192'(0));

    // Memory stage alone, three-cycle memory.
    drive_d(1'b1, DADDR, MSIZE8, 8'hff, DDATA);
    mem(1'b0, 64'h0);
    step();
    check("d_fwd1", 192'(s_oreq), 192'({1'b1, DADDR, MSIZE8, 8'hff, DDATA}));
    step();
    check("d_fwd2", 192'(s_oreq), 192'({1'b1, DADDR, MSIZE8, 8'hff, DDATA}));
    mem(1'b1, MDATA);
    step();
    check("d_fwd3", 192'(s_oreq), 192'({1'b1, DADDR, MSIZE8, 8'hff, DDATA}));
    check("d_dok", 192'(s_dresp.data_ok), 192'(1));
    check("d_iok", 192'({s_iresp.addr_ok, s_iresp.data_ok}), 192'(0));
    drive_d(1'b0, '0, MSIZE1, '0, '0);
    mem(1'b0, 64'h0);
    step();
    check("d_idle", 192'(s_oreq), 192'(0));

    // Fetch alone, single-cycle memory, both halves of the word.
    drive_i(1'b1, IADDR);
    mem(1'b1, MDATA);
    step();
    check("i_size", 192'(s_oreq.size), 192'(MSIZE4));
    check("i_strb", 192'(s_oreq.strobe), 192'(0));
    check("i_hi", 192'(s_iresp.data), 192'(32'hAAAA_BBBB));
    check("i_dok", 192'(s_iresp.data_ok), 192'(1));
    drive_i(1'b1, 64'h0000_0000_8000_0000);
    step();
    check("i_lo", 192'(s_iresp.data), 192'(32'hCCCC_DDDD));
    check("i_next", 192'(s_oreq.addr), 192'(64'h8000_0000));
    drive_i(1'b0, '0);
    mem(1'b0, 64'h0);
    step();

    // Contention: D first, then I after one idle cycle.
    drive_i(1'b1, IADDR);
    drive_d(1'b1, DADDR, MSIZE8, 8'h0f, DDATA);
    step();
    check("tie_d", 192'(s_oreq.addr), 192'(DADDR));
    check("tie_iwait", 192'({s_iresp.addr_ok, s_iresp.data_ok}), 192'(0));
    mem(1'b1, MDATA);
    step();
    drive_d(1'b0, '0, MSIZE1, '0, '0);
    mem(1'b0, 64'h0);
    step();
    check("tie_i_next", 192'(s_oreq.addr), 192'(IADDR));
    mem(1'b1, MDATA);
    step();
    drive_d(1'b1, DADDR, MSIZE8, 8'h0f, DDATA);
    step();
    check("tie2", 192'(s_oreq.addr), 192'(DADDR));
    step();
`ifdef MEM_BUS_ARBITER_RR_EN
    check("tie3", 192'(s_oreq.addr), 192'(IADDR));
`else
    check("tie3", 192'(s_oreq.addr), 192'(DADDR));
`endif
    drive_i(1'b0, '0);
    drive_d(1'b0, '0, MSIZE1, '0, '0);
    mem(1'b0, 64'h0);
    step();

    // Late D arrival while I is being served.
    drive_i(1'b1, IADDR);
    step();
    drive_d(1'b1, DADDR, MSIZE2, 8'h03, DDATA);
    step();
    check("late_hold", 192'(s_oreq.addr), 192'(IADDR));
    mem(1'b1, MDATA);
    step();
    check("late_done", 192'(s_oreq.addr), 192'(IADDR));
    drive_i(1'b0, '0);
    mem(1'b0, 64'h0);
    step();
    check("late_d", 192'(s_oreq.addr), 192'(DADDR));
    mem(1'b1, MDATA);
    step();
    drive_d(1'b0, '0, MSIZE1, '0, '0);
    mem(1'b0, 64'h0);

    // Reset while BUSY_D abandons the grant.
    drive_d(1'b1, DADDR, MSIZE8, 8'hff, DDATA);
    step(); step();
    reset = 1'b1;
    drive_d(1'b0, '0, MSIZE1, '0, '0);
    step();
    reset = 1'b0;
    step();
    check("rst_mid_oreq", 192'(s_oreq), 192'(0));
    check("rst_mid_dresp", 192'({s_dresp.addr_ok, s_dresp.data_ok}), 192'(0));
    drive_i(1'b1, IADDR);
    step();
    check("rst_regrant", 192'(s_oreq.addr), 192'(IADDR));
    mem(1'b1, MDATA);
    step();
    drive_i(1'b0, '0);
    mem(1'b0, 64'h0);
    step();

    // Random protocol-legal traffic.
    done_i = 1'b0;
    done_d = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 149) == 0) begin
        reset = 1'b1;
        bus.ireq = '0;
        bus.dreq = '0;
      end else begin
        reset = 1'b0;
        if (!bus.dreq.valid || done_d) begin
          if ($urandom_range(0, 9) < 4)
            drive_d(1'b1, {32'h0, $urandom}, msize_t'($urandom_range(0, 3)),
                    8'($urandom), {$urandom, $urandom});
          else
            drive_d(1'b0, '0, MSIZE1, '0, '0);
        end
        if (!bus.ireq.valid || done_i) begin
          if ($urandom_range(0, 9) < 5) drive_i(1'b1, {32'h0, $urandom});
          else drive_i(1'b0, '0);
        end
      end
      bus.oresp.addr_ok = 1'($urandom);
      bus.oresp.data_ok = 1'($urandom);
      bus.oresp.data    = {$urandom, $urandom};
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Two-to-one arbiter that shares the single core data-memory port between the instruction fetch stage (ibus) and the memory stage (dbus). It sits between the pipeline and the memory/cache side. It locks a grant for the duration of one transaction, which ends when addr_ok & data_ok are both high. It also adapts 32-bit instruction fetches onto the 64-bit dbus.

Parameters:
- none (address and data widths come from common::word_t / common::addr_t).

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- ireq  in  ibus_req_t  fetch request {valid, addr}.
- iresp  out  ibus_resp_t  fetch response {addr_ok, data_ok, data[31:0]}.
- dreq  in  dbus_req_t  memory-stage request {valid, addr, size, strobe, data}.
- dresp  out  dbus_resp_t  memory-stage response {addr_ok, data_ok, data[63:0]}.
- oreq  out  dbus_req_t  request to memory.
- oresp  in  dbus_resp_t  response from memory.

Behaviour:
- Clocking: one clock; reset is synchronous and active-high. The clock port is clk and the reset port is reset.
- State register: IDLE, BUSY_I, BUSY_D. Reset -> IDLE.
- Reset values: in the cycle after reset, oreq = '0, iresp = '0, dresp = '0.
- Completion is defined as done = oresp.addr_ok & oresp.data_ok.

Grant selection:
- In IDLE, sel is computed combinationally:
  - dreq.valid -> D.
  - else ireq.valid -> I.
  - else none.
- D has fixed priority because it is the older instruction.
- In BUSY_x, sel = x regardless of the valid inputs.

Forwarding (zero added latency):
- sel = D: oreq = dreq.
- sel = I: oreq.valid = ireq.valid, oreq.addr = ireq.addr, oreq.size = MSIZE4, oreq.strobe = 8'h00, oreq.data = '0.
- sel = none: oreq = '0.

Response routing:
- Only the selected requester sees oresp.addr_ok and oresp.data_ok. The other requester sees zeros.
- dresp.data = oresp.data.
- iresp.data = ireq.addr[2] ? oresp.data[63:32] : oresp.data[31:0].

State transitions:
- IDLE, sel = D, not done -> BUSY_D.
- IDLE, sel = I, not done -> BUSY_I.
- IDLE, done in the same cycle -> stays IDLE (single-cycle transaction).
- BUSY_x & done -> IDLE.
- BUSY_x & !done -> BUSY_x.

Requester rules:
- A requester holds valid and all fields stable until it observes done.
- A requester that deasserts valid mid-transaction is illegal. The arbiter remains locked to it until done.

Boundary conditions:
- Both requesters valid in IDLE -> D is served. I waits, with iresp = 0.
- ireq arriving while BUSY_D -> I is not forwarded. It is granted in the first IDLE cycle with no pending D.
- Back-to-back transactions: after done, the next grant is evaluated in the following cycle (one IDLE cycle minimum), except in the single-cycle case where done occurs while already in IDLE.
- Reset mid-transaction -> IDLE, and the grant is dropped. The memory side must tolerate an abandoned request.

Optional Feature:
- Macro: MEM_BUS_ARBITER_RR_EN.
- When defined:
  - A 1-bit last_grant register is added; reset value = D.
  - On each done, last_grant is updated to the completed requester.
  - On a tie in IDLE, the requester opposite to last_grant wins.
- Without the macro: fixed priority, D over I.

Decomposition:
- In package pipes: typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D} arb_state_t, and typedef enum logic {ARB_SEL_I, ARB_SEL_D} arb_sel_t.
- Reuse common::ibus_req_t / ibus_resp_t / dbus_req_t / dbus_resp_t and MSIZE4.
- One sub-module is natural: arb_pick, a combinational 2-way priority/RR chooser (inputs: valids, last_grant; output: sel, any).
- FSM and muxing live in mem_bus_arbiter.

Test Plan:
- D only: dreq {valid=1, addr=0x8000_0010, size=MSIZE8, strobe=0xff, data=0x1122334455667788}, memory done after 3 cycles -> oreq equals dreq on all 3 cycles; dresp.data_ok pulses on cycle 3; state returns to IDLE; iresp stays 0 throughout.
- I only: ireq addr=0x8000_0004, oresp.data=0xAAAA_BBBB_CCCC_DDDD -> oreq.size=MSIZE4, strobe=0; iresp.data=0xAAAA_BBBB. With addr=0x8000_0000 -> iresp.data=0xCCCC_DDDD.
- Contention: ireq and dreq both valid in cycle 0 -> D is granted; on D done, I is granted the next cycle. With MEM_BUS_ARBITER_RR_EN, a second tie after I completes goes to D, and the following tie goes to I.
- Late arrival: dreq rises while BUSY_I -> oreq stays the I request until done; D is granted in the following IDLE cycle.
- Single-cycle memory: done in the same cycle as the grant -> state never leaves IDLE; a fresh request is served the next cycle.
- Reset in BUSY_D -> next cycle state=IDLE, oreq='0, dresp='0; grant is re-evaluated from the valids afterwards.
